// File: rtl/gray_to_rgb_stream.sv
`default_nettype none
// gray_to_rgb_stream: two-stage gray -> 24-bit RGB expander with valid/ready handshake.
// Build macro GRAY_HEAT_MAP_EN enables the heat colour map (mode 2); otherwise mode 2 renders as gray.
module gray_to_rgb_stream #(
  parameter int FRAME_CNT_W  = 16,
  parameter int DEFAULT_MODE = 0
) (
  input  logic                   Sys_Clk,
  input  logic                   Rst_n,
  input  logic [1:0]             Mode_Sel,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [7:0]             In_Gray,
  input  logic                   In_Sof,
  input  logic                   In_Eol,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [7:0]             RGB_Data_R,
  output logic [7:0]             RGB_Data_G,
  output logic [7:0]             RGB_Data_B,
  output logic                   Out_Sof,
  output logic                   Out_Eol,
  output logic [FRAME_CNT_W-1:0] Frame_Cnt
);

  localparam logic [1:0] c_DEFAULT_MODE = (DEFAULT_MODE == 1) ? 2'd1 :
                                          (DEFAULT_MODE == 2) ? 2'd2 : 2'd0;

  logic                   w_en;
  logic [1:0]             w_sel;
  logic [1:0]             w_beat_mode;
  logic [7:0]             w_x4;
  logic [7:0]             w_r;
  logic [7:0]             w_g;
  logic [7:0]             w_b;

  logic [1:0]             r_active_mode;
  logic                   r_s1_valid;
  logic [7:0]             r_s1_gray;
  logic                   r_s1_sof;
  logic                   r_s1_eol;
  logic [1:0]             r_s1_mode;
  logic                   r_out_valid;
  logic [7:0]             r_out_r;
  logic [7:0]             r_out_g;
  logic [7:0]             r_out_b;
  logic                   r_out_sof;
  logic                   r_out_eol;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  assign w_en        = !r_out_valid || Out_Ready;
  assign w_sel       = (Mode_Sel == 2'd3) ? 2'd0 : Mode_Sel;
  assign w_beat_mode = In_Sof ? w_sel : r_active_mode;

  // Colour map of the stage-1 pixel; feeds the output register.
  always_comb begin
    w_x4 = {r_s1_gray[5:0], 2'b00};
    w_r  = r_s1_gray;
    w_g  = r_s1_gray;
    w_b  = r_s1_gray;
    case (r_s1_mode)
      2'd1: begin
        case (r_s1_gray[7:6])
          2'd0: begin w_r = 8'd0;   w_g = w_x4;   w_b = 8'd255; end
          2'd1: begin w_r = 8'd0;   w_g = 8'd255; w_b = ~w_x4;  end
          2'd2: begin w_r = w_x4;   w_g = 8'd255; w_b = 8'd0;   end
          default: begin w_r = 8'd255; w_g = ~w_x4; w_b = 8'd0; end
        endcase
      end
`ifdef GRAY_HEAT_MAP_EN
      2'd2: begin
        if (r_s1_gray < 8'd85) begin
          w_r = 8'(({2'b00, r_s1_gray}) * 10'd3);
          w_g = 8'd0;
          w_b = 8'd0;
        end else if (r_s1_gray < 8'd170) begin
          w_r = 8'd255;
          w_g = 8'(({2'b00, r_s1_gray} - 10'd85) * 10'd3);
          w_b = 8'd0;
        end else begin
          w_r = 8'd255;
          w_g = 8'd255;
          w_b = 8'(({2'b00, r_s1_gray} - 10'd170) * 10'd3);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Sys_Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_active_mode <= c_DEFAULT_MODE;
      r_s1_valid    <= 1'b0;
      r_s1_gray     <= '0;
      r_s1_sof      <= 1'b0;
      r_s1_eol      <= 1'b0;
      r_s1_mode     <= c_DEFAULT_MODE;
      r_out_valid   <= 1'b0;
      r_out_r       <= '0;
      r_out_g       <= '0;
      r_out_b       <= '0;
      r_out_sof     <= 1'b0;
      r_out_eol     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_en) begin
        r_s1_valid  <= In_Valid;
        r_out_valid <= r_s1_valid;
        if (In_Valid) begin
          r_s1_gray <= In_Gray;
          r_s1_sof  <= In_Sof;
          r_s1_eol  <= In_Eol;
          r_s1_mode <= w_beat_mode;
          if (In_Sof) begin
            r_active_mode <= w_sel;
          end
        end
        if (r_s1_valid) begin
          r_out_r   <= w_r;
          r_out_g   <= w_g;
          r_out_b   <= w_b;
          r_out_sof <= r_s1_sof;
          r_out_eol <= r_s1_eol;
        end
      end
      if (r_out_valid && Out_Ready && r_out_sof) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

  assign In_Ready   = w_en;
  assign Out_Valid  = r_out_valid;
  assign RGB_Data_R = r_out_r;
  assign RGB_Data_G = r_out_g;
  assign RGB_Data_B = r_out_b;
  assign Out_Sof    = r_out_sof;
  assign Out_Eol    = r_out_eol;
  assign Frame_Cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_rgb_stream.sv
`default_nettype none
// tb_gray_to_rgb_stream: directed and randomized checks of gray_to_rgb_stream against a pixel-level model.
module tb_gray_to_rgb_stream;

  logic        Sys_Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [1:0]  Mode_Sel = 2'd0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [7:0]  In_Gray = 8'd0;
  logic        In_Sof = 1'b0;
  logic        In_Eol = 1'b0;
  logic        Out_Valid;
  logic        Out_Ready = 1'b1;
  logic [7:0]  RGB_Data_R;
  logic [7:0]  RGB_Data_G;
  logic [7:0]  RGB_Data_B;
  logic        Out_Sof;
  logic        Out_Eol;
  logic [15:0] Frame_Cnt;

  gray_to_rgb_stream #(.FRAME_CNT_W(16), .DEFAULT_MODE(0)) dut (
    .Sys_Clk(Sys_Clk), .Rst_n(Rst_n), .Mode_Sel(Mode_Sel),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Gray(In_Gray),
    .In_Sof(In_Sof), .In_Eol(In_Eol),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .RGB_Data_R(RGB_Data_R), .RGB_Data_G(RGB_Data_G), .RGB_Data_B(RGB_Data_B),
    .Out_Sof(Out_Sof), .Out_Eol(Out_Eol), .Frame_Cnt(Frame_Cnt)
  );

  always #5 Sys_Clk = ~Sys_Clk;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
  } beat_t;

  beat_t exp_q[$];
  beat_t held;
  int    checks = 0;
  int    errors = 0;
  int    model_mode = 0;
  int    model_fcnt = 0;
  bit    prev_stall = 1'b0;
  int    stall_left = 0;
  bit    rand_ready = 1'b0;

  function automatic beat_t ref_map(int mode, int gv, logic sof, logic eol);
    beat_t o;
    int r = gv, g = gv, b = gv;
    int x4 = (gv % 64) * 4;
    if (mode == 1) begin
      if (gv < 64)       begin r = 0;   g = x4;       b = 255;      end
      else if (gv < 128) begin r = 0;   g = 255;      b = 255 - x4; end
      else if (gv < 192) begin r = x4;  g = 255;      b = 0;        end
      else               begin r = 255; g = 255 - x4; b = 0;        end
    end
`ifdef GRAY_HEAT_MAP_EN
    if (mode == 2) begin
      if (gv < 85)       begin r = 3 * gv; g = 0;              b = 0;              end
      else if (gv < 170) begin r = 255;    g = 3 * (gv - 85);  b = 0;              end
      else               begin r = 255;    g = 255;            b = 3 * (gv - 170); end
    end
`endif
    o.r = 8'(r); o.g = 8'(g); o.b = 8'(b); o.sof = sof; o.eol = eol;
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called just after a rising edge with inputs already driven; samples at the falling edge.
  task automatic tick(output bit acc);
    beat_t e;
    if (stall_left > 0) begin
      Out_Ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      Out_Ready = ($urandom_range(0, 3) != 0);
    end else begin
      Out_Ready = 1'b1;
    end
    @(negedge Sys_Clk);
    check("frame_cnt", 32'(Frame_Cnt), 32'(model_fcnt));
    check("in_ready", 32'(In_Ready), 32'(!(Out_Valid === 1'b1) || Out_Ready));
    if (prev_stall) begin
      check("stall_valid", 32'(Out_Valid), 32'd1);
      check("stall_hold", 32'({RGB_Data_R, RGB_Data_G, RGB_Data_B, Out_Sof, Out_Eol}), 32'(held));
    end
    if (Out_Valid === 1'b1 && Out_Ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rgb", 32'({RGB_Data_R, RGB_Data_G, RGB_Data_B}), 32'({e.r, e.g, e.b}));
        check("flags", 32'({Out_Sof, Out_Eol}), 32'({e.sof, e.eol}));
        if (e.sof) model_fcnt = (model_fcnt + 1) % 65536;
      end
    end
    prev_stall = (Out_Valid === 1'b1) && !Out_Ready;
    held = {RGB_Data_R, RGB_Data_G, RGB_Data_B, Out_Sof, Out_Eol};
    acc = In_Valid && (In_Ready === 1'b1);
    if (acc) begin
      if (In_Sof) model_mode = (Mode_Sel == 2'd3) ? 0 : int'(Mode_Sel);
      exp_q.push_back(ref_map(model_mode, int'(In_Gray), In_Sof, In_Eol));
    end
    @(posedge Sys_Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] gv, input logic sof, input logic eol, input logic [1:0] ms);
    bit acc = 1'b0;
    In_Valid = 1'b1; In_Gray = gv; In_Sof = sof; In_Eol = eol; Mode_Sel = ms;
    for (int k = 0; k < 50; k++) begin
      tick(acc);
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'd1, 32'd0);
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    In_Valid = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick(acc);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    tick(acc);
  endtask

  initial begin
    bit acc;
    // Reset state
    repeat (2) @(posedge Sys_Clk);
    #1;
    check("rst_valid", 32'(Out_Valid), 32'd0);
    check("rst_rgb", 32'({RGB_Data_R, RGB_Data_G, RGB_Data_B}), 32'd0);
    check("rst_flags", 32'({Out_Sof, Out_Eol}), 32'd0);
    check("rst_fcnt", 32'(Frame_Cnt), 32'd0);
    check("rst_ready", 32'(In_Ready), 32'd1);
    @(negedge Sys_Clk);
    Rst_n = 1'b1;
    @(posedge Sys_Clk);
    #1;

    // Latency: SOF beat g=0x5A in mode 0
    send(8'h5A, 1'b1, 1'b0, 2'd0);
    check("lat1_valid", 32'(Out_Valid), 32'd0);
    tick(acc);
    check("lat2_valid", 32'(Out_Valid), 32'd1);
    check("lat2_rgb", 32'({RGB_Data_R, RGB_Data_G, RGB_Data_B}), 32'h5A5A5A);
    check("lat2_sof", 32'(Out_Sof), 32'd1);
    drain();
    check("fcnt_after_first", 32'(Frame_Cnt), 32'd1);

    // Rainbow boundaries
    send(8'd63, 1'b1, 1'b0, 2'd1);
    send(8'd64, 1'b0, 1'b0, 2'd0);
    send(8'd127, 1'b0, 1'b0, 2'd0);
    send(8'd128, 1'b0, 1'b0, 2'd0);
    send(8'd192, 1'b0, 1'b0, 2'd0);
    send(8'd255, 1'b0, 1'b1, 2'd0);
    drain();

    // Heat boundaries (gray when the heat map is not built)
    send(8'd84, 1'b1, 1'b0, 2'd2);
    send(8'd85, 1'b0, 1'b0, 2'd0);
    send(8'd169, 1'b0, 1'b0, 2'd0);
    send(8'd170, 1'b0, 1'b0, 2'd0);
    send(8'd200, 1'b0, 1'b0, 2'd0);
    send(8'd255, 1'b1, 1'b1, 2'd2);
    drain();

    // Backpressure: 10 beats with a 3-cycle sink stall mid-stream
    for (int i = 0; i < 10; i++) begin
      if (i == 4) stall_left = 3;
      send(8'(i * 23 + 7), i == 0, i == 9, 2'd1);
    end
    drain();

    // Mode change on non-SOF beats is ignored; mode 3 on SOF means gray
    send(8'd100, 1'b1, 1'b0, 2'd0);
    send(8'd150, 1'b0, 1'b0, 2'd1);
    send(8'd30, 1'b0, 1'b1, 2'd1);
    send(8'd30, 1'b1, 1'b0, 2'd3);
    send(8'd220, 1'b0, 1'b1, 2'd1);
    drain();

    // Reset with two beats in flight
    send(8'd10, 1'b1, 1'b0, 2'd1);
    send(8'd20, 1'b0, 1'b0, 2'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(Out_Valid), 32'd0);
    check("mid_rst_rgb", 32'({RGB_Data_R, RGB_Data_G, RGB_Data_B}), 32'd0);
    check("mid_rst_fcnt", 32'(Frame_Cnt), 32'd0);
    exp_q.delete();
    model_mode = 0;
    model_fcnt = 0;
    prev_stall = 1'b0;
    @(negedge Sys_Clk);
    Rst_n = 1'b1;
    @(posedge Sys_Clk);
    #1;
    send(8'd40, 1'b0, 1'b0, 2'd1);
    send(8'd77, 1'b1, 1'b1, 2'd1);
    send(8'd140, 1'b0, 1'b0, 2'd0);
    drain();

    // Randomized traffic with random sink readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        In_Gray = 8'($urandom);
        Mode_Sel = 2'($urandom);
        tick(acc);
      end else begin
        send(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 2'($urandom));
      end
    end
    rand_ready = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
